// File: rtl/mem_loader.sv
// Byte-stream program loader: packs little-endian byte pairs into 16-bit words,
// writes them to consecutive memory addresses and keeps a running checksum.
module mem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] length,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    localparam logic [15:0] LIMIT = 16'(DEPTH - BASE_ADDR);
    localparam logic [15:0] BASE  = 16'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, LO, HI, WR} state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] length_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;

    // Address and data come straight from registers, so both hold for the whole WR cycle.
    assign mem_addr  = BASE + count;
    assign mem_wdata = {hi_q, lo_q};

    // Moore outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            length_q   <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        checksum <= '0;
                        count    <= '0;
                        length_q <= length;
                        if (length > LIMIT) begin
                            error <= 1'b1;
                        end else if (length == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= LO;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                LO: begin
                    if (byte_valid && byte_ready) begin
                        lo_q  <= byte_in;
                        state <= HI;
                    end
                end
                HI: begin
                    if (byte_valid && byte_ready) begin
                        hi_q       <= byte_in;
                        state      <= WR;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                    end
                end
                WR: begin
                    mem_we   <= 1'b0;
                    checksum <= checksum + {hi_q, lo_q};
                    count    <= count + 16'd1;
                    if (count + 16'd1 == length_q) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= LO;
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: random byte streams compared against a
// word-level model of the expected memory writes and checksum.
module tb_mem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] length = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    int n_checks = 0;
    int n_fail   = 0;

    // Every cycle with mem_we high is one logged write {addr, data}.
    logic [31:0] wr_q[$];

    mem_loader #(.DEPTH(256), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .length     (length),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic do_start(input logic [15:0] len);
        @(negedge clk);
        start  = 1'b1;
        length = len;
        @(negedge clk);
        start  = 1'b0;
        length = 16'($urandom);
    endtask

    // Called at a negedge; offers each byte after a gap and waits for the transfer.
    task automatic send_bytes(input bq_t b, input int gap_min, input int gap_max, output bit ok);
        int gap;
        int t;
        ok = 1'b1;
        foreach (b[i]) begin
            gap = $urandom_range(gap_max, gap_min);
            byte_valid = 1'b0;
            repeat (gap) begin
                byte_in = 8'($urandom);
                @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_in    = b[i];
            t = 0;
            while (!byte_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!byte_ready) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = !busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready got %b exp 0", byte_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b exp 0", error); end
        n_checks++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL reset_checksum got %h exp 0000", checksum); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bq_t b;
        bit  ok;
        b = '{8'h34, 8'h12, 8'h78, 8'h56};
        wr_q.delete();
        do_start(16'd2);
        send_bytes(b, 0, 0, ok);
        if (ok) wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got busy=%b exp 0", busy); end
        n_checks++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL basic_nwrites got %0d exp 2", wr_q.size()); end
        n_checks++; if (wr_q.size() > 0 && wr_q[0] !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_w0 got %h exp 00001234", wr_q[0]); end
        n_checks++; if (wr_q.size() > 1 && wr_q[1] !== 32'h0001_5678) begin n_fail++; $display("FAIL basic_w1 got %h exp 00015678", wr_q[1]); end
        n_checks++; if (checksum !== 16'h68AC) begin n_fail++; $display("FAIL basic_checksum got %h exp 68ac", checksum); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b exp 0", busy); end
    endtask

    task automatic test_error;
        bq_t b;
        bit  ok;
        wr_q.delete();
        do_start(16'd257);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_error got %b exp 1", error); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL err_done got %b exp 0", done); end
        n_checks++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL err_checksum got %h exp 0000", checksum); end
        n_checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL err_idle got busy=%b ready=%b exp 0 0", busy, byte_ready); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL err_nwrites got %0d exp 0", wr_q.size()); end
        b = '{8'hAB, 8'hCD};
        do_start(16'd1);
        n_checks++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_clear got error=%b busy=%b exp 0 1", error, busy); end
        send_bytes(b, 0, 2, ok);
        if (ok) wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL err_timeout got busy=%b exp 0", busy); end
        n_checks++; if (wr_q.size() !== 1 || wr_q[0] !== 32'h0000_CDAB) begin n_fail++; $display("FAIL err_reload got n=%0d w=%h exp 1 0000cdab", wr_q.size(), wr_q[0]); end
        n_checks++; if (done !== 1'b1 || checksum !== 16'hCDAB) begin n_fail++; $display("FAIL err_reload_status got done=%b sum=%h exp 1 cdab", done, checksum); end
    endtask

    task automatic test_zero_length;
        wr_q.delete();
        do_start(16'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", done); end
        n_checks++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL zero_checksum got %h exp 0000", checksum); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b exp 0", busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (wr_q.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_quiet got n=%0d busy=%b exp 0 0", wr_q.size(), busy); end
    endtask

    task automatic test_gaps_and_start;
        bq_t b;
        bit  ok;
        b = '{8'h5A, 8'hC3};
        wr_q.delete();
        do_start(16'd1);
        start  = 1'b1;
        length = 16'd3;
        @(negedge clk);
        start  = 1'b0;
        send_bytes(b, 5, 5, ok);
        if (ok) wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gaps_timeout got busy=%b exp 0", busy); end
        repeat (10) @(negedge clk);
        n_checks++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL gaps_nwrites got %0d exp 1", wr_q.size()); end
        n_checks++; if (wr_q.size() > 0 && wr_q[0] !== 32'h0000_C35A) begin n_fail++; $display("FAIL gaps_word got %h exp 0000c35a", wr_q[0]); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL gaps_status got done=%b busy=%b exp 1 0", done, busy); end
    endtask

    task automatic test_full_depth;
        bq_t b;
        bit  ok;
        int  bad;
        for (int i = 0; i < 512; i++) b.push_back(8'hFF);
        wr_q.delete();
        do_start(16'd256);
        send_bytes(b, 0, 0, ok);
        if (ok) wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout got busy=%b exp 0", busy); end
        n_checks++; if (wr_q.size() !== 256) begin n_fail++; $display("FAIL full_nwrites got %0d exp 256", wr_q.size()); end
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== {16'(i), 16'hFFFF}) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_words got %0d bad words exp 0", bad); end
        n_checks++; if (wr_q.size() > 0 && wr_q[wr_q.size()-1][31:16] !== 16'h00FF) begin n_fail++; $display("FAIL full_last_addr got %h exp 00ff", wr_q[wr_q.size()-1][31:16]); end
        n_checks++; if (checksum !== 16'hFF00) begin n_fail++; $display("FAIL full_checksum got %h exp ff00", checksum); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done got %b exp 1", done); end
    endtask

    task automatic test_back_to_back;
        bq_t         b;
        bit          ok;
        int          len;
        int          sum;
        logic [15:0] w;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(16, 1);
            b.delete();
            for (int i = 0; i < 2 * len; i++) b.push_back(8'($urandom));
            wr_q.delete();
            do_start(16'(len));
            send_bytes(b, 0, (it % 2 == 0) ? 0 : 3, ok);
            if (ok) wait_idle(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout got busy=%b exp 0", it, busy); end
            n_checks++; if (wr_q.size() !== len) begin n_fail++; $display("FAIL rand%0d_nwrites got %0d exp %0d", it, wr_q.size(), len); end
            sum = 0;
            for (int i = 0; i < len; i++) begin
                w = {b[2*i+1], b[2*i]};
                sum = sum + int'(w);
                n_checks++;
                if (i >= wr_q.size() || wr_q[i] !== {16'(i), w}) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d got %h exp %h", it, i, (i < wr_q.size()) ? wr_q[i] : 32'hx, {16'(i), w});
                end
            end
            n_checks++; if (checksum !== 16'(sum % 65536)) begin n_fail++; $display("FAIL rand%0d_checksum got %h exp %h", it, checksum, 16'(sum % 65536)); end
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done got %b exp 1", it, done); end
        end
    endtask

    task automatic test_reset_mid_load;
        bq_t b;
        bit  ok;
        b = '{8'h11, 8'h22};
        wr_q.delete();
        do_start(16'd4);
        send_bytes(b, 0, 0, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (byte_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got ready=%b we=%b busy=%b exp 0 0 0", byte_ready, mem_we, busy); end
        n_checks++; if (done !== 1'b0 || error !== 1'b0 || checksum !== 16'h0000) begin n_fail++; $display("FAIL rstmid_status got done=%b err=%b sum=%h exp 0 0 0000", done, error, checksum); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rstmid_addr got %h exp 0000", mem_addr); end
        n_checks++; if (wr_q.size() !== 1 || wr_q[0] !== 32'h0000_2211) begin n_fail++; $display("FAIL rstmid_first got n=%0d w=%h exp 1 00002211", wr_q.size(), wr_q[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        b = '{8'h9E, 8'h47};
        do_start(16'd1);
        send_bytes(b, 0, 1, ok);
        if (ok) wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout got busy=%b exp 0", busy); end
        n_checks++; if (wr_q.size() !== 2 || wr_q[1] !== 32'h0000_479E) begin n_fail++; $display("FAIL rstmid_fresh got n=%0d w=%h exp 2 0000479e", wr_q.size(), wr_q[1]); end
        n_checks++; if (done !== 1'b1 || checksum !== 16'h479E) begin n_fail++; $display("FAIL rstmid_status2 got done=%b sum=%h exp 1 479e", done, checksum); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_zero_length();
        test_gaps_and_start();
        test_full_depth();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
